register_file: RTL and testbench
================================

# register_file

MIPS-style general-purpose register file: 32 registers, each 32 bits wide, with two combinational read ports and one synchronous write port. It sits in the datapath decode stage. It supplies the rs/rt operands and accepts write-back results. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH (32)

Ports:
- Clk  input  1  clock; all writes commit on the rising edge
- Rst_n  input  1  reset, asynchronous and active-low
- ReadRegister1  input  ADDR_WIDTH  index for read port 1
- ReadRegister2  input  ADDR_WIDTH  index for read port 2
- WriteRegister  input  ADDR_WIDTH  index for the write port
- WriteData  input  DATA_WIDTH  data to write
- RegWrite  input  1  write enable, active-high
- ReadData1  output  DATA_WIDTH  contents of register ReadRegister1
- ReadData2  output  DATA_WIDTH  contents of register ReadRegister2

One clock; reset is asynchronous and active-low.

## Operation
- Storage: 32 × DATA_WIDTH flip-flop array, named regs[0..31].
- Reset: while Rst_n = 0, all regs clear to 0. Reset takes effect immediately, with no clock needed. A write pending at reset assertion is discarded.
- Write: on a rising edge of Clk with Rst_n = 1 and RegWrite = 1:
  - regs[WriteRegister] <= WriteData.
  - If WriteRegister = 0, the write is ignored and regs[0] stays 0.
- Read: each read port is purely combinational.
  - ReadDataN = regs[ReadRegisterN].
  - Index 0 always reads 0.
- The two read ports are independent. Both may address the same register and both return the same value.
- Unknown or X read indices are not sanitized. No error output exists.

## Timing
- Write latency: 1 clock. A value written at edge k is visible on the read ports immediately after edge k.
- Read latency: 0 cycles, combinational from ReadRegisterN to ReadDataN.
- Same-cycle read and write to the same index, without REGFILE_BYPASS_EN:
  - The read returns the old value until the edge.
  - The read returns the new value after the edge.
- Reset values: ReadData1 and ReadData2 are 0 for every index while and after reset, until a write occurs.
- Rst_n deassertion is synchronous to Clk at system level. The first write is possible on the first rising edge after deassertion.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When RegWrite = 1, WriteRegister ≠ 0 and ReadRegisterN = WriteRegister, ReadDataN = WriteData combinationally in the same cycle. Storage still updates at the edge.
- Undefined: no forwarding. Reads always reflect stored contents, as described in Timing.

## Test plan
- Reset, then read every index pair → all ReadData = 0.
- Write regs 1..9 with 11, 22, …, 99 on consecutive edges; set RegWrite = 0; read pairs (0,1), (2,3), (4,5), (6,7), (8,9) → (0,11), (22,33), (44,55), (66,77), (88,99).
- Rewrite regs 1..9 with 111, 222, …, 999; read pairs (9,8), (7,6), (5,4), (3,2), (1,0) → (999,888), (777,666), (555,444), (333,222), (111,0).
- Write 0xDEADBEEF to reg 0 with RegWrite = 1 → reg 0 still reads 0. Set RegWrite = 0 with WriteRegister = 5 and WriteData = 7 → reg 5 is unchanged.
- Write 0x1234 to reg 20. Assert Rst_n = 0 mid-cycle, with no clock edge → ReadData for index 20 is 0 immediately. Writes are ignored while Rst_n = 0.
- Drive ReadRegister1 = WriteRegister = 10, WriteData = 0xA5 and RegWrite = 1, then sample before the edge:
  - Without the macro → old value of reg 10.
  - With REGFILE_BYPASS_EN → 0xA5.
  - Both builds → 0xA5 after the edge.

Source files
------------

// File: rtl/register_file.sv
// MIPS-style 32x32 register file: two combinational read ports, one synchronous write port, r0 hardwired to 0.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  writeValid;

    assign writeValid = RegWrite && (WriteRegister != '0);

    // NOTE: the array is flops, not a RAM macro, so it can take the async clear; RAMs cannot be reset like this.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeValid) begin
            // NOTE: non-blocking so every reader in this edge sees the pre-edge value.
            regs[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] data;
        data = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (writeValid && (addr == WriteRegister)) begin
            data = WriteData;
        end
`endif
        return data;
    endfunction

    always_comb begin
        ReadData1 = readPort(ReadRegister1);
        ReadData2 = readPort(ReadRegister2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow the bypass macro when it is defined.
module tb_register_file;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    logic                  Clk;
    logic                  Rst_n;
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;

    int passCount  = 0;
    int checkCount = 0;

    register_file #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs always change 1 time unit after a rising edge, well away from the next one.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic writeReg(input int idx, input logic [DATA_WIDTH-1:0] data);
        WriteRegister = ADDR_WIDTH'(idx);
        WriteData     = data;
        RegWrite      = 1'b1;
        tick();
        RegWrite      = 1'b0;
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 32; i++) begin
                ReadRegister1 = ADDR_WIDTH'(i);
                ReadRegister2 = ADDR_WIDTH'(31 - i);
                #1;
                checkCount++;
                if (ReadData1 !== '0 || ReadData2 !== '0)
                    $display("FAIL reset_read phase=%0d idx=%0d got (%h,%h) expected (0,0)",
                             pass, i, ReadData1, ReadData2);
                else
                    passCount++;
            end
            if (pass == 0) begin
                tick();
                Rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 1; i <= 9; i++) writeReg(i, DATA_WIDTH'(11 * i));
        for (int k = 0; k < 5; k++) begin
            ReadRegister1 = ADDR_WIDTH'(2 * k);
            ReadRegister2 = ADDR_WIDTH'(2 * k + 1);
            #1;
            checkCount++;
            if (ReadData1 !== DATA_WIDTH'(22 * k) || ReadData2 !== DATA_WIDTH'(11 * (2 * k + 1)))
                $display("FAIL write_read pair=(%0d,%0d) got (%0d,%0d) expected (%0d,%0d)",
                         2 * k, 2 * k + 1, ReadData1, ReadData2, 22 * k, 11 * (2 * k + 1));
            else
                passCount++;
        end
    endtask

    task automatic test_rewrite();
        for (int i = 1; i <= 9; i++) writeReg(i, DATA_WIDTH'(111 * i));
        for (int k = 0; k < 5; k++) begin
            int hi;
            int lo;
            hi = 9 - 2 * k;
            lo = 8 - 2 * k;
            ReadRegister1 = ADDR_WIDTH'(hi);
            ReadRegister2 = ADDR_WIDTH'(lo);
            #1;
            checkCount++;
            if (ReadData1 !== DATA_WIDTH'(111 * hi) || ReadData2 !== DATA_WIDTH'(111 * lo))
                $display("FAIL rewrite pair=(%0d,%0d) got (%0d,%0d) expected (%0d,%0d)",
                         hi, lo, ReadData1, ReadData2, 111 * hi, 111 * lo);
            else
                passCount++;
        end
    endtask

    task automatic test_reg0_and_disable();
        writeReg(0, 32'hDEAD_BEEF);
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        #1;
        checkCount++;
        if (ReadData1 !== '0 || ReadData2 !== '0)
            $display("FAIL reg0_write got (%h,%h) expected (0,0)", ReadData1, ReadData2);
        else
            passCount++;

        WriteRegister = 5'd5;
        WriteData     = 32'd7;
        RegWrite      = 1'b0;
        tick();
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd4;
        #1;
        checkCount++;
        if (ReadData1 !== 32'd555 || ReadData2 !== 32'd444)
            $display("FAIL write_disabled got (%0d,%0d) expected (555,444)", ReadData1, ReadData2);
        else
            passCount++;
    endtask

    task automatic test_async_reset();
        writeReg(20, 32'h1234);
        ReadRegister1 = 5'd20;
        ReadRegister2 = 5'd9;
        #1;
        checkCount++;
        if (ReadData1 !== 32'h1234 || ReadData2 !== 32'd999)
            $display("FAIL pre_reset got (%h,%0d) expected (1234,999)", ReadData1, ReadData2);
        else
            passCount++;

        // Mid-cycle assertion with a write pending: clear must be immediate and the write dropped.
        WriteRegister = 5'd20;
        WriteData     = 32'hFFFF;
        RegWrite      = 1'b1;
        #1;
        Rst_n = 1'b0;
        #1;
        checkCount++;
        if (ReadData1 !== '0 || ReadData2 !== '0)
            $display("FAIL async_reset got (%h,%h) expected (0,0)", ReadData1, ReadData2);
        else
            passCount++;

        tick();
        checkCount++;
        if (ReadData1 !== '0)
            $display("FAIL write_in_reset got %h expected 0", ReadData1);
        else
            passCount++;
        RegWrite = 1'b0;
        Rst_n    = 1'b1;
    endtask

    task automatic test_same_cycle();
        logic [DATA_WIDTH-1:0] expBefore;
        writeReg(10, 32'h55);
        ReadRegister1 = 5'd10;
        ReadRegister2 = 5'd10;
        WriteRegister = 5'd10;
        WriteData     = 32'hA5;
        RegWrite      = 1'b1;
`ifdef REGFILE_BYPASS_EN
        expBefore = 32'hA5;
`else
        expBefore = 32'h55;
`endif
        #1;
        checkCount++;
        if (ReadData1 !== expBefore || ReadData2 !== expBefore)
            $display("FAIL same_cycle_before got (%h,%h) expected (%h,%h)",
                     ReadData1, ReadData2, expBefore, expBefore);
        else
            passCount++;

        tick();
        RegWrite = 1'b0;
        #1;
        checkCount++;
        if (ReadData1 !== 32'hA5 || ReadData2 !== 32'hA5)
            $display("FAIL same_cycle_after got (%h,%h) expected (a5,a5)", ReadData1, ReadData2);
        else
            passCount++;

        // Writes to index 0 must never be forwarded either.
        ReadRegister1 = '0;
        WriteRegister = '0;
        WriteData     = 32'hCAFE;
        RegWrite      = 1'b1;
        #1;
        checkCount++;
        if (ReadData1 !== '0)
            $display("FAIL reg0_forward got %h expected 0", ReadData1);
        else
            passCount++;
        tick();
        RegWrite = 1'b0;
    endtask

    initial begin
        Rst_n         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;

        test_reset();
        test_write_read();
        test_rewrite();
        test_reg0_and_disable();
        test_async_reset();
        test_same_cycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
